// File: rtl/exec_pkg.sv
// Shared constants for the execute/memory slice: datapath widths and ALU op encodings.
package exec_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_MASK   = 3'b101;
  localparam logic [2:0] OP_PASS_B = 3'b110;
  localparam logic [2:0] OP_PASS_A = 3'b111;

endpackage

// File: rtl/exec_data_ram.sv
// Data memory: synchronous write, asynchronous read, cleared to zero by the core reset.
module exec_data_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: every word is in the reset domain, so this array maps to flops rather
  // than a RAM macro; that is the price of the guaranteed all-zero state after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the 8-bit core: ALU, barrel shifter, C/Z flags and data memory.
module exec_mem_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic              alu_use_carry,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [2:0]        bitcount,
  input  logic              dir,
  input  logic              sh_ro_bar,
  input  logic              select_c,
  input  logic              select_z,
  input  logic              write_c,
  input  logic              write_z,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_co,
  output logic              alu_z,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_c,
  output logic              shift_z,
  output logic [DATA_W-1:0] mem_out_data,
  output logic              C,
  output logic              Z
);

  import exec_pkg::*;

  logic              c_q, c_d;
  logic              z_q, z_d;
  logic              cin;
  logic [DATA_W:0]   sum9, diff9;
  logic [DATA_W:0]   shl9, shr9;
  logic [2*DATA_W-1:0] rol16, ror16;

  assign cin   = alu_use_carry & c_q;
  assign sum9  = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, cin};
  // The ninth bit of the extended difference is the borrow: set iff a < b + cin.
  assign diff9 = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, cin};

  // NOTE: assign every output a default first so no path through the case leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    alu_out = '0;
    alu_co  = 1'b0;
    unique case (alu_op)
      OP_ADD:    {alu_co, alu_out} = sum9;
      OP_SUB:    {alu_co, alu_out} = diff9;
      OP_AND:    alu_out = alu_a & alu_b;
      OP_OR:     alu_out = alu_a | alu_b;
      OP_XOR:    alu_out = alu_a ^ alu_b;
      OP_MASK:   alu_out = alu_a & ~alu_b;
      OP_PASS_B: alu_out = alu_b;
      OP_PASS_A: alu_out = alu_a;
      default:   alu_out = '0;
    endcase
  end

  assign alu_z = (alu_out == '0);

  // Widened shifts expose the last bit pushed out at the extra bit position.
  assign shl9  = {1'b0, shift_data} << bitcount;
  assign shr9  = {shift_data, 1'b0} >> bitcount;
  assign rol16 = {shift_data, shift_data} << bitcount;
  assign ror16 = {shift_data, shift_data} >> bitcount;

  always_comb begin
    shift_out = shift_data;
    shift_c   = 1'b0;
    if (bitcount != 3'd0) begin
      unique case ({sh_ro_bar, dir})
        2'b10: {shift_c, shift_out} = shl9;
        2'b11: {shift_out, shift_c} = shr9;
        2'b00: begin
          shift_out = rol16[2*DATA_W-1:DATA_W];
          shift_c   = shift_out[0];
        end
        default: begin
          shift_out = ror16[DATA_W-1:0];
          shift_c   = shift_out[DATA_W-1];
        end
      endcase
    end
  end

  assign shift_z = (shift_out == '0);

  always_comb begin
    c_d = c_q;
    z_d = z_q;
    if (write_c) c_d = select_c ? shift_c : alu_co;
    if (write_z) z_d = select_z ? shift_z : alu_z;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
    end
  end

  assign C = c_q;
  assign Z = z_q;

  exec_data_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_data_ram (
    .clk  (clk),
    .reset(reset),
    .we   (mem_write),
    .addr (mem_addr),
    .wdata(mem_write_data),
    .rdata(mem_out_data)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit: ALU, shifter, flags, memory and reset.
module tb_exec_mem_unit;
  import exec_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_use_carry;
  logic [7:0] shift_data;
  logic [2:0] bitcount;
  logic       dir, sh_ro_bar, select_c, select_z, write_c, write_z, mem_write;
  logic [7:0] mem_addr, mem_write_data;
  logic [7:0] alu_out, shift_out, mem_out_data;
  logic       alu_co, alu_z, shift_c, shift_z, C, Z;

  int checks = 0;
  int fails  = 0;

  exec_mem_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_use_carry(alu_use_carry), .shift_data(shift_data), .bitcount(bitcount),
    .dir(dir), .sh_ro_bar(sh_ro_bar), .select_c(select_c), .select_z(select_z),
    .write_c(write_c), .write_z(write_z), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .shift_out(shift_out), .shift_c(shift_c), .shift_z(shift_z),
    .mem_out_data(mem_out_data), .C(C), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    checks++; if (C !== 1'b0) begin fails++; $display("FAIL reset_C: got %b expected 0", C); end
    checks++; if (Z !== 1'b0) begin fails++; $display("FAIL reset_Z: got %b expected 0", Z); end
    mem_addr = 8'h3A; #1;
    checks++; if (mem_out_data !== 8'h00) begin fails++; $display("FAIL reset_mem: got %h expected 00", mem_out_data); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    alu_op = OP_ADD; alu_a = 8'hF0; alu_b = 8'h10; alu_use_carry = 1'b0;
    select_c = 1'b0; select_z = 1'b0; write_c = 1'b1; write_z = 1'b1;
    #1;
    checks++; if ({alu_co, alu_out, alu_z} !== {1'b1, 8'h00, 1'b1})
      begin fails++; $display("FAIL add: got co=%b out=%h z=%b expected co=1 out=00 z=1", alu_co, alu_out, alu_z); end
    @(posedge clk); #1;
    write_c = 1'b0; write_z = 1'b0;
    checks++; if ({C, Z} !== 2'b11) begin fails++; $display("FAIL add_flags: got C=%b Z=%b expected 11", C, Z); end
  endtask

  task automatic test_addc_sub();
    @(negedge clk);
    alu_op = OP_ADD; alu_a = 8'h01; alu_b = 8'h01; alu_use_carry = 1'b1; #1;
    checks++; if ({alu_co, alu_out} !== {1'b0, 8'h03})
      begin fails++; $display("FAIL addc: got co=%b out=%h expected co=0 out=03", alu_co, alu_out); end
    alu_op = OP_SUB; alu_a = 8'h05; alu_b = 8'h06; alu_use_carry = 1'b0; #1;
    checks++; if ({alu_co, alu_out} !== {1'b1, 8'hFF})
      begin fails++; $display("FAIL sub: got co=%b out=%h expected co=1 out=FF", alu_co, alu_out); end
    alu_a = 8'h05; alu_b = 8'h03; alu_use_carry = 1'b1; #1;
    checks++; if ({alu_co, alu_out} !== {1'b0, 8'h01})
      begin fails++; $display("FAIL subc: got co=%b out=%h expected co=0 out=01", alu_co, alu_out); end
    alu_a = 8'h00; alu_b = 8'hFF; #1;
    checks++; if ({alu_co, alu_out, alu_z} !== {1'b1, 8'h00, 1'b1})
      begin fails++; $display("FAIL subc_wrap: got co=%b out=%h z=%b expected co=1 out=00 z=1", alu_co, alu_out, alu_z); end
    alu_use_carry = 1'b0;
  endtask

  task automatic test_logic();
    logic [2:0] ops [6];
    logic [7:0] exp [6];
    ops = '{OP_AND, OP_OR, OP_XOR, OP_MASK, OP_PASS_B, OP_PASS_A};
    exp = '{8'h30, 8'hFC, 8'hCC, 8'hC0, 8'h3C, 8'hF0};
    alu_a = 8'hF0; alu_b = 8'h3C;
    for (int i = 0; i < 6; i++) begin
      alu_op = ops[i]; #1;
      checks++; if ({alu_co, alu_out} !== {1'b0, exp[i]})
        begin fails++; $display("FAIL logic_op%0d: got co=%b out=%h expected co=0 out=%h", ops[i], alu_co, alu_out, exp[i]); end
    end
  endtask

  task automatic test_shifter();
    // {data, n, dir, sh_ro_bar, expected out, expected c}
    logic [7:0] d   [6];
    logic [2:0] n   [6];
    logic       dr  [6];
    logic       sr  [6];
    logic [7:0] eo  [6];
    logic       ec  [6];
    d  = '{8'h81, 8'h81, 8'h81, 8'hB4, 8'h81, 8'h01};
    n  = '{3'd1,  3'd1,  3'd0,  3'd3,  3'd3,  3'd1};
    dr = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1};
    sr = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    eo = '{8'h02, 8'hC0, 8'h81, 8'h16, 8'h0C, 8'h00};
    ec = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    for (int i = 0; i < 6; i++) begin
      shift_data = d[i]; bitcount = n[i]; dir = dr[i]; sh_ro_bar = sr[i]; #1;
      checks++; if ({shift_out, shift_c, shift_z} !== {eo[i], ec[i], eo[i] == 8'h00})
        begin fails++; $display("FAIL shift%0d: got out=%h c=%b z=%b expected out=%h c=%b", i, shift_out, shift_c, shift_z, eo[i], ec[i]); end
    end
  endtask

  task automatic test_memory();
    @(negedge clk);
    mem_addr = 8'h3A; mem_write_data = 8'hA5; mem_write = 1'b1; #1;
    checks++; if (mem_out_data !== 8'h00) begin fails++; $display("FAIL mem_pre_write: got %h expected 00", mem_out_data); end
    @(posedge clk); #1;
    checks++; if (mem_out_data !== 8'hA5) begin fails++; $display("FAIL mem_post_write: got %h expected A5", mem_out_data); end
    mem_write = 1'b0; mem_addr = 8'h3B; #1;
    checks++; if (mem_out_data !== 8'h00) begin fails++; $display("FAIL mem_neighbour: got %h expected 00", mem_out_data); end
    mem_addr = 8'h3A; #1;
    checks++; if (mem_out_data !== 8'hA5) begin fails++; $display("FAIL mem_readback: got %h expected A5", mem_out_data); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    alu_op = OP_ADD; alu_a = 8'hF0; alu_b = 8'h10; select_c = 1'b0; select_z = 1'b0;
    write_c = 1'b1; write_z = 1'b1;
    @(posedge clk); #1;
    write_c = 1'b0; write_z = 1'b0;
    checks++; if ({C, Z} !== 2'b11) begin fails++; $display("FAIL rst_setup_flags: got C=%b Z=%b expected 11", C, Z); end
    @(negedge clk);
    mem_addr = 8'h3A; mem_write_data = 8'h5A; mem_write = 1'b1; write_c = 1'b1; write_z = 1'b1;
    #2 reset = 1'b0; #1;
    checks++; if ({C, Z} !== 2'b00) begin fails++; $display("FAIL rst_flags: got C=%b Z=%b expected 00", C, Z); end
    checks++; if (mem_out_data !== 8'h00) begin fails++; $display("FAIL rst_mem: got %h expected 00", mem_out_data); end
    @(posedge clk); #1;
    checks++; if ({mem_out_data, C, Z} !== {8'h00, 2'b00})
      begin fails++; $display("FAIL rst_hold: got mem=%h C=%b Z=%b expected mem=00 C=0 Z=0", mem_out_data, C, Z); end
    @(negedge clk);
    mem_write = 1'b0; write_c = 1'b0; write_z = 1'b0; reset = 1'b1; #1;
    checks++; if (mem_out_data !== 8'h00) begin fails++; $display("FAIL rst_release_mem: got %h expected 00", mem_out_data); end
  endtask

  task automatic test_flag_hold();
    @(negedge clk);
    alu_op = OP_ADD; alu_a = 8'hF0; alu_b = 8'h10; select_c = 1'b0; write_c = 1'b1; write_z = 1'b0;
    @(posedge clk); #1;
    write_c = 1'b0;
    checks++; if ({C, Z} !== 2'b10) begin fails++; $display("FAIL hold_c_only: got C=%b Z=%b expected 10", C, Z); end
    @(negedge clk);
    alu_a = 8'h01; alu_b = 8'h00;
    shift_data = 8'h01; bitcount = 3'd1; dir = 1'b1; sh_ro_bar = 1'b1;
    select_z = 1'b1; write_z = 1'b1;
    @(posedge clk); #1;
    write_z = 1'b0;
    checks++; if ({C, Z} !== 2'b11) begin fails++; $display("FAIL hold_z_shift: got C=%b Z=%b expected 11", C, Z); end
    @(negedge clk);
    alu_a = 8'hF0; alu_b = 8'h10;
    shift_data = 8'h01; bitcount = 3'd1; dir = 1'b0; sh_ro_bar = 1'b1;
    select_c = 1'b1; write_c = 1'b1;
    @(posedge clk); #1;
    write_c = 1'b0;
    checks++; if ({C, Z} !== 2'b01) begin fails++; $display("FAIL c_from_shift: got C=%b Z=%b expected 01", C, Z); end
  endtask

  initial begin
    reset = 1'b1;
    alu_op = OP_ADD; alu_a = '0; alu_b = '0; alu_use_carry = 1'b0;
    shift_data = '0; bitcount = '0; dir = 1'b0; sh_ro_bar = 1'b0;
    select_c = 1'b0; select_z = 1'b0; write_c = 1'b0; write_z = 1'b0;
    mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
    #2 reset = 1'b0;
    test_reset();
    test_add();
    test_addc_sub();
    test_logic();
    test_shifter();
    test_memory();
    test_reset_mid_op();
    test_flag_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
